multiplicador_uc: RTL and testbench

Control unit (UC) for the shift-add multiplier datapath `multiplicador_fd`. It accepts a start/ack handshake from the system, sequences the datapath's register enables, loads and counter, and consumes `qlsb` and `zero`. It signals completion while `P_out` is valid. It also runs an independent shift watchdog that flags a datapath counter fault.

---
 rtl/multiplicador_pkg.sv | 28 ++
 rtl/watchdog_cnt.sv | 27 ++
 rtl/multiplicador_uc.sv | 128 ++++++++++++
 tb/tb_multiplicador_uc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplicador_pkg.sv
// Shared types and constants for the shift-add multiplier control unit.
// Latency and watchdog sizing are expressed as functions of the operand width.
package multiplicador_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Edges from the start-sampling edge until done is visible:
    // one to capture start, one for LOAD, two per iteration.
    function automatic int latency_cycles(input int width);
        return 2 + 2 * width;
    endfunction

    function automatic int wd_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_LATENCY = latency_cycles(DEFAULT_WIDTH);
    localparam int DEFAULT_WD_W    = wd_width(DEFAULT_WIDTH);

endpackage

// File: rtl/watchdog_cnt.sv
// Saturating up-counter of SHIFT states per product, with a terminal-compare flag.
module watchdog_cnt #(
    parameter int LIMIT = 8,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          at_limit
);

    assign at_limit = (count == CW'(LIMIT));

    // Saturates so a stuck datapath can never wrap the count back into range.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/multiplicador_uc.sv
// Control unit for the shift-add multiplier datapath: start/ack handshake,
// ADD/SHIFT sequencing, synchronous abort and a shift-count watchdog.
module multiplicador_uc
    import multiplicador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    input  logic abort,
    input  logic qlsb,
    input  logic zero,
    output logic a_rst,
    output logic a_en,
    output logic b_en,
    output logic q_en,
    output logic cnt_en,
    output logic a_ld,
    output logic b_ld,
    output logic q_ld,
    output logic cnt_ld,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int WDW = wd_width(WIDTH);

    state_t         state;
    state_t         next_state;
    logic           start_q;
    logic           load_r;
    logic           add_r;
    logic           shift_r;
    logic           done_r;
    logic           busy_r;
    logic [WDW-1:0] wd_count;
    logic           wd_at_limit;
    logic           wd_first;
    logic           wd_late;
    logic           wd_early;
    logic           wd_clr;
    logic           wd_inc;

    watchdog_cnt #(
        .LIMIT (WIDTH),
        .CW    (WDW)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (wd_clr),
        .inc      (wd_inc),
        .count    (wd_count),
        .at_limit (wd_at_limit)
    );

    // The count already includes the SHIFT currently being executed.
    assign wd_first = (wd_count == WDW'(1)) && (WIDTH > 1);
    assign wd_late  = (state == SHIFT) && !abort && wd_at_limit && !zero;
    assign wd_early = (state == SHIFT) && !abort && wd_first && zero;
    assign wd_clr   = (state == LOAD);
    assign wd_inc   = (next_state == SHIFT);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = start_q ? LOAD : IDLE;
            LOAD:  next_state = abort ? IDLE : ADD;
            ADD:   next_state = abort ? IDLE : SHIFT;
            SHIFT: begin
                if (abort || wd_late) begin
                    next_state = IDLE;
                end else if (zero) begin
                    next_state = DONE;
                end else begin
                    next_state = ADD;
                end
            end
            DONE:    next_state = ack ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    // State-decoded flags are registered from next_state so they track the state register exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            start_q <= 1'b0;
            load_r  <= 1'b0;
            add_r   <= 1'b0;
            shift_r <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= next_state;
            start_q <= (state == IDLE) && (next_state == IDLE) && start;
            load_r  <= (next_state == LOAD);
            add_r   <= (next_state == ADD);
            shift_r <= (next_state == SHIFT);
            done_r  <= (next_state == DONE);
            busy_r  <= (next_state == LOAD) || (next_state == ADD) || (next_state == SHIFT);
            if (wd_late || wd_early) begin
                err <= 1'b1;
            end
        end
    end

    assign a_rst  = load_r;
    assign b_en   = load_r;
    assign b_ld   = load_r;
    assign q_ld   = load_r;
    assign cnt_ld = load_r;
    assign q_en   = load_r | shift_r;
    assign a_ld   = add_r & qlsb;
    assign a_en   = shift_r | (add_r & qlsb);
    assign cnt_en = shift_r & ~zero;
    assign busy   = busy_r;
    assign done   = done_r;

    a_busy_done_exclusive: assert property (@(posedge clk) disable iff (!rst) !(busy && done));
    a_load_implies_enable: assert property (@(posedge clk) disable iff (!rst) a_ld |-> a_en);
    a_done_quiet:          assert property (@(posedge clk) disable iff (!rst)
                                            done |-> !(a_en || b_en || q_en || cnt_en || cnt_ld));

endmodule

// File: tb/tb_multiplicador_uc.sv
// Directed bench: the control unit drives a behavioural shift-add datapath model.
module tb_multiplicador_uc;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic ack = 1'b0;
    logic abort = 1'b0;
    logic qlsb;
    logic zero;
    logic a_rst, a_en, b_en, q_en, cnt_en, a_ld, b_ld, q_ld, cnt_ld, busy, done, err;
    logic [11:0] outs;
    logic is_shift;
    logic is_add;

    logic [8:0] a_r = '0;
    logic [7:0] b_r = '0;
    logic [7:0] q_r = '0;
    logic [2:0] cnt_r = '0;
    logic [7:0] b_in = '0;
    logic [7:0] q_in = '0;
    int zero_mode = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  b;
        logic [7:0]  q;
        logic [15:0] prod;
        logic [7:0]  ald_pat;
        int          hold;
        logic        ack_with_start;
    } vec_t;

    vec_t vecs[8];

    multiplicador_uc #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ack    (ack),
        .abort  (abort),
        .qlsb   (qlsb),
        .zero   (zero),
        .a_rst  (a_rst),
        .a_en   (a_en),
        .b_en   (b_en),
        .q_en   (q_en),
        .cnt_en (cnt_en),
        .a_ld   (a_ld),
        .b_ld   (b_ld),
        .q_ld   (q_ld),
        .cnt_ld (cnt_ld),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    assign outs     = {a_rst, a_en, b_en, q_en, cnt_en, a_ld, b_ld, q_ld, cnt_ld, busy, done, err};
    assign is_shift = a_en && q_en && !a_ld && !q_ld;
    assign is_add   = busy && !q_en && !b_en;
    assign qlsb     = q_r[0];
    assign zero     = (zero_mode == 1) ? 1'b0 : (zero_mode == 2) ? 1'b1 : (cnt_r == 3'd0);

    // Behavioural datapath: 9-bit A holds the add carry that shifts into the product.
    always @(posedge clk) begin
        if (a_rst) begin
            a_r <= '0;
        end else if (a_en) begin
            a_r <= a_ld ? ({1'b0, a_r[7:0]} + {1'b0, b_r}) : {1'b0, a_r[8:1]};
        end
        if (b_en) begin
            b_r <= b_ld ? b_in : {1'b0, b_r[7:1]};
        end
        if (q_en) begin
            q_r <= q_ld ? q_in : {a_r[0], q_r[7:1]};
        end
        if (cnt_ld) begin
            cnt_r <= 3'd7;
        end else if (cnt_en) begin
            cnt_r <= cnt_r - 3'd1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic ab);
        start = s;
        ack   = a;
        abort = ab;
    endtask

    task automatic runOp(input logic [7:0] bv, input logic [7:0] qv, output int lat,
                         output logic [7:0] pat, output int shifts, output int loads,
                         output logic fin_done, output logic [15:0] prod);
        int add_idx;
        b_in = bv;
        q_in = qv;
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        lat = -1;
        pat = '0;
        shifts = 0;
        loads = 0;
        fin_done = 1'b0;
        add_idx = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (b_ld) loads++;
            if (is_add) begin
                if (add_idx < 8) pat[add_idx] = a_ld;
                add_idx++;
            end
            if (is_shift) shifts++;
            if (done) begin
                fin_done = 1'b1;
                lat = cyc;
                break;
            end
            if (cyc >= 2 && !busy) begin
                lat = cyc;
                break;
            end
        end
        prod = {a_r[7:0], q_r};
    endtask

    task automatic releaseDone(input int hold, input logic with_start, input string tag);
        int held = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (done && !busy) held++;
        end
        checkOutput({tag, " done held"}, held, hold);
        applyStimulus(with_start, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput({tag, " idle after ack"}, int'(outs[11:1]), 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput({tag, " no relaunch"}, int'(outs[11:1]), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int lat, shifts, loads, held, seen;
        logic [7:0] pat;
        logic [15:0] prod;
        logic fin_done, found, aborted;

        vecs[0] = '{8'd13,  8'd11,  16'd143,   8'h0B, 10, 1'b0};
        vecs[1] = '{8'd255, 8'd0,   16'd0,     8'h00, 2,  1'b1};
        vecs[2] = '{8'd1,   8'd1,   16'd1,     8'h01, 1,  1'b0};
        vecs[3] = '{8'd128, 8'd2,   16'd256,   8'h02, 1,  1'b0};
        vecs[4] = '{8'd0,   8'd200, 16'd0,     8'hC8, 1,  1'b1};
        vecs[5] = '{8'd200, 8'd3,   16'd600,   8'h03, 1,  1'b0};
        vecs[6] = '{8'd17,  8'd170, 16'd2890,  8'hAA, 1,  1'b0};
        vecs[7] = '{8'd255, 8'd128, 16'd32640, 8'h80, 1,  1'b0};

        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("reset outputs", int'(outs), 0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        held = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (outs == 12'd0) held++;
        end
        checkOutput("idle after reset", held, 5);

        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i].b, vecs[i].q, lat, pat, shifts, loads, fin_done, prod);
            checkOutput($sformatf("v%0d done reached", i), int'(fin_done), 1);
            checkOutput($sformatf("v%0d latency", i), lat, 18);
            checkOutput($sformatf("v%0d product", i), int'(prod), int'(vecs[i].prod));
            checkOutput($sformatf("v%0d a_ld pattern", i), int'(pat), int'(vecs[i].ald_pat));
            checkOutput($sformatf("v%0d shifts", i), shifts, 8);
            checkOutput($sformatf("v%0d loads", i), loads, 1);
            checkOutput($sformatf("v%0d err", i), int'(err), 0);
            releaseDone(vecs[i].hold, vecs[i].ack_with_start, $sformatf("v%0d", i));
        end

        $display("[TB] abort in third SHIFT");
        b_in = 8'd100;
        q_in = 8'd77;
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        shifts = 0;
        aborted = 1'b0;
        for (int cyc = 1; cyc <= 30 && !aborted; cyc++) begin
            @(negedge clk);
            if (is_shift) shifts++;
            if (shifts == 3) begin
                applyStimulus(1'b0, 1'b0, 1'b1);
                @(negedge clk);
                applyStimulus(1'b0, 1'b0, 1'b0);
                aborted = 1'b1;
            end
        end
        checkOutput("abort reached 3rd shift", int'(aborted), 1);
        checkOutput("abort idle", int'(outs), 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checkOutput("abort no done", seen, 0);
        runOp(8'd255, 8'd255, lat, pat, shifts, loads, fin_done, prod);
        checkOutput("post-abort latency", lat, 18);
        checkOutput("post-abort product", int'(prod), 65025);
        releaseDone(2, 1'b0, "post-abort");

        $display("[TB] async reset during ADD");
        b_in = 8'd255;
        q_in = 8'd255;
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        found = 1'b0;
        for (int cyc = 1; cyc <= 10 && !found; cyc++) begin
            @(negedge clk);
            if (is_add && a_en) found = 1'b1;
        end
        checkOutput("mid-ADD reached", int'(found), 1);
        #2 rst = 1'b0;
        #1 checkOutput("async reset outputs", int'(outs), 0);
        @(negedge clk);
        rst = 1'b1;
        runOp(8'd7, 8'd9, lat, pat, shifts, loads, fin_done, prod);
        checkOutput("post-reset latency", lat, 18);
        checkOutput("post-reset product", int'(prod), 63);
        releaseDone(1, 1'b0, "post-reset");

        $display("[TB] watchdog with zero stuck low");
        zero_mode = 1;
        runOp(8'd21, 8'd5, lat, pat, shifts, loads, fin_done, prod);
        zero_mode = 0;
        checkOutput("stuck0 no done", int'(fin_done), 0);
        checkOutput("stuck0 idle edge", lat, 18);
        checkOutput("stuck0 shifts", shifts, 8);
        checkOutput("stuck0 err", int'(err), 1);
        checkOutput("stuck0 idle outputs", int'(outs[11:1]), 0);
        runOp(8'd3, 8'd3, lat, pat, shifts, loads, fin_done, prod);
        checkOutput("sticky product", int'(prod), 9);
        checkOutput("sticky err", int'(err), 1);
        releaseDone(1, 1'b0, "sticky");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("err cleared by reset", int'(outs), 0);
        rst = 1'b1;

        $display("[TB] watchdog with zero stuck high");
        zero_mode = 2;
        runOp(8'd6, 8'd7, lat, pat, shifts, loads, fin_done, prod);
        checkOutput("stuck1 done", int'(fin_done), 1);
        checkOutput("stuck1 latency", lat, 4);
        checkOutput("stuck1 shifts", shifts, 1);
        checkOutput("stuck1 err", int'(err), 1);
        releaseDone(2, 1'b0, "stuck1");
        zero_mode = 0;
        checkOutput("stuck1 err sticky", int'(err), 1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("stuck1 err cleared", int'(err), 0);
        rst = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
